// File: rtl/dot_pkg.sv
// Shared types and width helpers for the streaming dot-product accumulator.
package dot_pkg;

  typedef struct packed {
    logic valid;
    logic last;
    logic first;
  } beat_sb_t;

  function automatic int prod_w(input int size_a, input int size_b);
    return size_a + size_b + 2;
  endfunction

  function automatic int tree_depth(input int num);
    return $clog2(num);
  endfunction

  function automatic int tree_w(input int size, input int num);
    return size + $clog2(num);
  endfunction

  // Number of live nodes at a given tree level; odd leftovers round up.
  function automatic int tree_nodes(input int num, input int lvl);
    return (num + (1 << lvl) - 1) >> lvl;
  endfunction

  // Signed add saturated to a w-bit two's complement range (w <= 62).
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               sat
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s   = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    sat = (s > hi) || (s < lo);
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/dot_stream_acc_if.sv
// Beat input and result output bundle of the dot-product accumulator.
interface dot_stream_acc_if #(
  parameter int LANES = 16,
  parameter int SIZEA = 8,
  parameter int SIZEB = 8,
  parameter int ACCW  = 32
);
  logic                   in_valid;
  logic                   in_last;
  logic                   a_signed;
  logic                   b_signed;
  logic [SIZEA-1:0]       din_a [0:LANES-1];
  logic [SIZEB-1:0]       din_b [0:LANES-1];
  logic                   out_valid;
  logic signed [ACCW-1:0] dout;
  logic                   out_sat;

  modport master (
    output in_valid, in_last, a_signed, b_signed, din_a, din_b,
    input  out_valid, dout, out_sat
  );

  modport slave (
    input  in_valid, in_last, a_signed, b_signed, din_a, din_b,
    output out_valid, dout, out_sat
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Registered signed adder tree for any NUM >= 2, with beat sideband delayed to match.
module adder_tree_pipe
  import dot_pkg::*;
#(
  parameter  int SIZE = 18,
  parameter  int NUM  = 16,
  localparam int T    = tree_depth(NUM),
  localparam int OW   = tree_w(SIZE, NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic signed [SIZE-1:0] din [0:NUM-1],
  input  beat_sb_t              sb_in,
  output logic signed [OW-1:0]  sum,
  output beat_sb_t              sb_out
);

  genvar gi, gj;
  generate
    for (gi = 0; gi <= T; gi++) begin : g_lvl
      localparam int N = tree_nodes(NUM, gi);
      localparam int W = SIZE + gi;
      logic signed [W-1:0] node [0:N-1];

      if (gi == 0) begin : g_in
        for (gj = 0; gj < N; gj++) begin : g_node
          assign node[gj] = din[gj];
        end
      end else begin : g_add
        localparam int NP = tree_nodes(NUM, gi - 1);
        logic signed [W-1:0] node_d [0:N-1];
        for (gj = 0; gj < N; gj++) begin : g_node
          // An unpaired last node is carried through a register to keep alignment.
          if (2 * gj + 1 < NP) begin : g_pair
            assign node_d[gj] = W'(g_lvl[gi-1].node[2*gj]) + W'(g_lvl[gi-1].node[2*gj+1]);
          end else begin : g_pass
            assign node_d[gj] = W'(g_lvl[gi-1].node[2*gj]);
          end
        end
        always_ff @(posedge clk) begin
          node <= node_d;
        end
      end
    end
  endgenerate

  beat_sb_t sb_q [0:T-1];
  beat_sb_t sb_d [0:T-1];

  always_comb begin
    sb_d[0] = sb_in;
    for (int i = 1; i < T; i++) begin
      sb_d[i] = sb_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < T; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      sb_q <= sb_d;
    end
  end

  assign sum    = g_lvl[T].node[0];
  assign sb_out = sb_q[T-1];

endmodule

// File: rtl/dot_stream_acc.sv
// Streaming LANES-wide dot product with per-vector saturating accumulation.
module dot_stream_acc
  import dot_pkg::*;
#(
  parameter int LANES = 16,
  parameter int SIZEA = 8,
  parameter int SIZEB = 8,
  parameter int ACCW  = 32
) (
  input  logic            clk,
  input  logic            rst,
  dot_stream_acc_if.slave bus
);

  localparam int PW = prod_w(SIZEA, SIZEB);
  localparam int SW = tree_w(PW, LANES);

  logic signed [SIZEA:0]   a_ext_d [0:LANES-1];
  logic signed [SIZEA:0]   a_ext_q [0:LANES-1];
  logic signed [SIZEB:0]   b_ext_d [0:LANES-1];
  logic signed [SIZEB:0]   b_ext_q [0:LANES-1];
  logic signed [PW-1:0]    prod_d  [0:LANES-1];
  logic signed [PW-1:0]    prod_q  [0:LANES-1];
  beat_sb_t                sb0_d, sb0_q, sb1_q, tree_sb;
  logic                    first_d, first_q;
  logic signed [SW-1:0]    tree_sum;
  logic signed [63:0]      acc_base;
  logic signed [ACCW-1:0]  acc_sum;
  logic                    beat_sat;
  logic signed [ACCW-1:0]  acc_d, acc_q, dout_d, dout_q;
  logic                    sat_d, sat_q, out_valid_d, out_valid_q, out_sat_d, out_sat_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_ext_d[i] = {bus.a_signed & bus.din_a[i][SIZEA-1], bus.din_a[i]};
      b_ext_d[i] = {bus.b_signed & bus.din_b[i][SIZEB-1], bus.din_b[i]};
      prod_d[i]  = PW'(a_ext_q[i]) * PW'(b_ext_q[i]);
    end
    sb0_d   = '{valid: bus.in_valid, last: bus.in_valid & bus.in_last, first: first_q};
    first_d = bus.in_valid ? bus.in_last : first_q;
  end

  always_ff @(posedge clk) begin
    a_ext_q <= a_ext_d;
    b_ext_q <= b_ext_d;
    prod_q  <= prod_d;
    if (rst) begin
      sb0_q   <= '0;
      sb1_q   <= '0;
      first_q <= 1'b1;
    end else begin
      sb0_q   <= sb0_d;
      sb1_q   <= sb0_q;
      first_q <= first_d;
    end
  end

  adder_tree_pipe #(
    .SIZE (PW),
    .NUM  (LANES)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .din    (prod_q),
    .sb_in  (sb1_q),
    .sum    (tree_sum),
    .sb_out (tree_sb)
  );

  // A first beat restarts from zero so the previous vector never leaks in.
  always_comb begin
    acc_base    = tree_sb.first ? 64'sd0 : 64'(acc_q);
    acc_sum     = ACCW'(sat_add(acc_base, 64'(tree_sum), ACCW, beat_sat));
    acc_d       = acc_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    dout_d      = dout_q;
    out_sat_d   = out_sat_q;
    if (tree_sb.valid) begin
      acc_d = acc_sum;
      sat_d = beat_sat | (sat_q & ~tree_sb.first);
      if (tree_sb.last) begin
        out_valid_d = 1'b1;
        dout_d      = acc_sum;
        out_sat_d   = sat_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_dot_stream_acc.sv
// Directed bench: a 32-bit and a narrow 20-bit accumulator fed identical beats.
module tb_dot_stream_acc;

  localparam int LANES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  dot_stream_acc_if #(.LANES(LANES), .SIZEA(8), .SIZEB(8), .ACCW(32)) bus32 ();
  dot_stream_acc_if #(.LANES(LANES), .SIZEA(8), .SIZEB(8), .ACCW(20)) bus20 ();

  dot_stream_acc #(.LANES(LANES), .SIZEA(8), .SIZEB(8), .ACCW(32)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  dot_stream_acc #(.LANES(LANES), .SIZEA(8), .SIZEB(8), .ACCW(20)) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (bus20)
  );

  typedef struct {
    int     cyc;
    longint d;
    bit     s;
  } ev_t;

  ev_t q32[$];
  ev_t q20[$];

  always @(negedge clk) begin
    if (bus32.out_valid) q32.push_back('{cyc, longint'(bus32.dout), bus32.out_sat});
    if (bus20.out_valid) q20.push_back('{cyc, longint'(bus20.dout), bus20.out_sat});
  end

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    bit         as;
    bit         bs;
    longint     exp32;
    bit         use20;
    longint     exp20;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_idle_inputs();
    bus32.in_valid = 1'b0; bus32.in_last = 1'b0; bus32.a_signed = 1'b0; bus32.b_signed = 1'b0;
    bus20.in_valid = 1'b0; bus20.in_last = 1'b0; bus20.a_signed = 1'b0; bus20.b_signed = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      bus32.din_a[i] = '0; bus32.din_b[i] = '0;
      bus20.din_a[i] = '0; bus20.din_b[i] = '0;
    end
  endtask

  // Present one beat (all lanes equal) for one clock; returns the cycle it was presented in.
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit as, input bit bs,
                      input bit last, output int n);
    bus32.in_valid = 1'b1; bus32.in_last = last; bus32.a_signed = as; bus32.b_signed = bs;
    bus20.in_valid = 1'b1; bus20.in_last = last; bus20.a_signed = as; bus20.b_signed = bs;
    for (int i = 0; i < LANES; i++) begin
      bus32.din_a[i] = a; bus32.din_b[i] = b;
      bus20.din_a[i] = a; bus20.din_b[i] = b;
    end
    @(posedge clk);
    #1;
    n = cyc - 1;
    bus32.in_valid = 1'b0; bus32.in_last = 1'b0;
    bus20.in_valid = 1'b0; bus20.in_last = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Waits until cycle 'at' has been observed, then checks the next result of each DUT.
  task automatic expect_vec(input string name, input int at, input longint d32, input bit s32,
                            input bit use20, input longint d20, input bit s20);
    ev_t e;
    while (cyc < at + 1) @(negedge clk);
    if (q32.size() == 0) begin
      total++; bad++;
      $display("FAIL %s_valid32: got no out_valid expected one at cycle %0d", name, at);
    end else begin
      e = q32.pop_front();
      chk({name, "_cyc32"}, e.cyc, at);
      chk({name, "_dout32"}, e.d, d32);
      chk({name, "_sat32"}, e.s, s32);
      $display("vec %s: cycle=%0d dout32=%0d sat32=%0d", name, e.cyc, e.d, e.s);
    end
    if (q20.size() == 0) begin
      if (use20) begin
        total++; bad++;
        $display("FAIL %s_valid20: got no out_valid expected one at cycle %0d", name, at);
      end
    end else begin
      e = q20.pop_front();
      if (use20) begin
        chk({name, "_cyc20"}, e.cyc, at);
        chk({name, "_dout20"}, e.d, d20);
        chk({name, "_sat20"}, e.s, s20);
        $display("vec %s: cycle=%0d dout20=%0d sat20=%0d", name, e.cyc, e.d, e.s);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n2;

    vecs[0] = '{"ss_min",    8'h80, 8'h80, 1'b1, 1'b1,  262144, 1'b1,  262144};
    vecs[1] = '{"uu_max",    8'hFF, 8'hFF, 1'b0, 1'b0, 1040400, 1'b0,       0};
    vecs[2] = '{"mixed",     8'hFF, 8'hFF, 1'b1, 1'b0,   -4080, 1'b1,   -4080};
    vecs[3] = '{"ones",      8'h01, 8'h01, 1'b1, 1'b1,      16, 1'b1,      16};
    vecs[4] = '{"ss_mix",    8'h7F, 8'h80, 1'b1, 1'b1, -260096, 1'b1, -260096};
    vecs[5] = '{"us_mix",    8'h80, 8'h80, 1'b0, 1'b1, -262144, 1'b1, -262144};

    drive_idle_inputs();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("reset_valid", bus32.out_valid, 0);
    chk("reset_dout", bus32.dout, 0);
    chk("reset_sat", bus32.out_sat, 0);

    // Four-beat vector of ones: latency and multi-beat accumulation.
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, n);
    expect_vec("four_beat", n + 7, 64, 1'b0, 1'b1, 64, 1'b0);
    idle(3);
    chk("hold_valid", bus32.out_valid, 0);
    chk("hold_dout", bus32.dout, 64);

    for (int v = 0; v < 6; v++) begin
      beat(vecs[v].a, vecs[v].b, vecs[v].as, vecs[v].bs, 1'b1, n);
      expect_vec(vecs[v].name, n + 7, vecs[v].exp32, 1'b0, vecs[v].use20, vecs[v].exp20, 1'b0);
    end

    // Narrow accumulator overflows on the second beat; next vector starts clean.
    beat(8'h80, 8'h80, 1'b1, 1'b1, 1'b0, n);
    beat(8'h80, 8'h80, 1'b1, 1'b1, 1'b1, n);
    expect_vec("sat_two", n + 7, 524288, 1'b0, 1'b1, 524287, 1'b1);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, n);
    expect_vec("after_sat", n + 7, 16, 1'b0, 1'b1, 16, 1'b0);

    // Back-to-back single-beat vectors.
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, n);
    beat(8'd2, 8'd1, 1'b1, 1'b1, 1'b1, n2);
    chk("b2b_adjacent", n2 - n, 1);
    expect_vec("b2b_first", n + 7, 16, 1'b0, 1'b1, 16, 1'b0);
    expect_vec("b2b_second", n2 + 7, 32, 1'b0, 1'b1, 32, 1'b0);

    // Three beats separated by idle cycles: 16 + 96 - 16.
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    idle(2);
    beat(8'd2, 8'd3, 1'b1, 1'b1, 1'b0, n);
    idle(1);
    beat(8'hFF, 8'd1, 1'b1, 1'b1, 1'b1, n);
    expect_vec("gaps", n + 7, 96, 1'b0, 1'b1, 96, 1'b0);

    // Reset in the middle of a vector discards everything in flight.
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0, n);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    chk("rst_no_out32", q32.size(), 0);
    chk("rst_no_out20", q20.size(), 0);
    chk("rst_dout", bus32.dout, 0);
    chk("rst_sat", bus32.out_sat, 0);
    chk("rst_valid", bus32.out_valid, 0);
    beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b1, n);
    expect_vec("after_rst", n + 7, 16, 1'b0, 1'b1, 16, 1'b0);

    idle(10);
    chk("no_extra32", q32.size(), 0);
    chk("no_extra20", q20.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
